// File: rtl/count_uart_tx.sv
// Sends each change of the 4-bit count as one ASCII hex character on an 8N1 UART line.
// Optional build macro COUNT_UART_CRLF_EN appends a CR and an LF frame after every character.
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_i,
  input  logic             en_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [3:0]        prev_q, prev_d;
  logic              pend_q, pend_d;
  logic [3:0]        pend_val_q, pend_val_d;
  logic              overrun_q, overrun_d;

  logic [3:0] cnt_lo;
  logic       chg;
  logic       baud_done;
  logic       load_any;
  logic       load_pend;
  logic [7:0] load_byte;
  logic       unused_count;

  // Only the low nibble is encoded; the reduction keeps the upper bits formally consumed.
  assign unused_count = ^count_i;
  assign cnt_lo    = count_i[3:0];
  assign chg       = (cnt_lo != prev_q) & en_i;
  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef COUNT_UART_CRLF_EN
  // chr_q: 0 = hex char in flight (or none), 1 = CR due/in flight, 2 = LF due/in flight.
  logic [1:0] chr_q, chr_d;
  assign load_pend = (state_q == S_IDLE) & pend_q & (chr_q == 2'd0);
  assign load_any  = (state_q == S_IDLE) & (pend_q | (chr_q != 2'd0));
  assign load_byte = (chr_q == 2'd1) ? 8'h0D :
                     (chr_q == 2'd2) ? 8'h0A : hex_ascii(pend_val_q);
`else
  assign load_pend = (state_q == S_IDLE) & pend_q;
  assign load_any  = load_pend;
  assign load_byte = hex_ascii(pend_val_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      prev_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      overrun_q  <= 1'b0;
`ifdef COUNT_UART_CRLF_EN
      chr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      overrun_q  <= overrun_d;
`ifdef COUNT_UART_CRLF_EN
      chr_q      <= chr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_any) state_d = S_START;
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d     = (state_q == S_IDLE || baud_done) ? '0 : baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    prev_d     = cnt_lo;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    overrun_d  = overrun_q;
`ifdef COUNT_UART_CRLF_EN
    chr_d      = chr_q;
`endif

    case (state_q)
      S_IDLE: if (load_any) begin
        shift_d = load_byte;
        bit_d   = '0;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
      S_START: if (baud_done) tx_d = shift_q[0];
      S_DATA: if (baud_done) begin
        if (bit_q == 3'd7) begin
          tx_d = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: if (baud_done) begin
`ifdef COUNT_UART_CRLF_EN
        if (chr_q == 2'd2) begin
          chr_d  = 2'd0;
          busy_d = 1'b0;
        end else begin
          chr_d  = chr_q + 2'd1;
        end
`else
        busy_d = 1'b0;
`endif
      end
      default: ;
    endcase

    // A load frees the buffer first, so a change on the same edge is not an overrun.
    if (load_pend) pend_d = 1'b0;
    if (chg) begin
      if (pend_d) overrun_d = 1'b1;
      pend_d     = 1'b1;
      pend_val_d = cnt_lo;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Random and directed stimulus for count_uart_tx, checked per cycle against a frame-timing model
// and by a UART receiver that decodes tx_o against the queue of expected characters.
module tb_count_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b1;
  logic [3:0] count_i = 4'h0;
  logic       tx_o, busy_o, overrun_o;

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .count_i(count_i), .en_i(en_i),
    .tx_o(tx_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [3:0] n);
    int v;
    v = n;
    return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
  endfunction

  // Reference model: which frame is on the line and when it started, in plain edge counts.
  logic [3:0] m_prev = 4'h0;
  logic [3:0] m_val  = 4'h0;
  bit         m_pend = 1'b0;
  bit         m_ovr  = 1'b0;
  bit         m_active = 1'b0;
  int         m_edge = 0;
  int         m_start = 0;
  int         m_next_load = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_prev = 4'h0; m_val = 4'h0; m_pend = 1'b0; m_ovr = 1'b0; m_active = 1'b0;
      m_edge = 0; m_start = 0; m_next_load = 0;
      exp_q.delete();
    end else begin
      m_edge++;
      if (m_pend && m_edge >= m_next_load) begin
        m_byte      = ascii_of(m_val);
        m_start     = m_edge;
        m_next_load = m_edge + FRAME + 1;
        m_active    = 1'b1;
        m_pend      = 1'b0;
        exp_q.push_back(m_byte);
      end
      if (en_i && count_i != m_prev) begin
        if (m_pend) m_ovr = 1'b1;
        m_pend = 1'b1;
        m_val  = count_i;
      end
      m_prev = count_i;
    end
  end

  always @(negedge clk) begin
    int off;
    logic e_tx, e_busy;
    if (!rst && chk_on) begin
      off    = m_edge - m_start;
      e_busy = m_active && off < FRAME;
      if (!e_busy)            e_tx = 1'b1;
      else if (off < CPB)     e_tx = 1'b0;
      else if (off < 9 * CPB) e_tx = m_byte[off / CPB - 1];
      else                    e_tx = 1'b1;
      check("tx", 32'(tx_o), 32'(e_tx));
      check("busy", 32'(busy_o), 32'(e_busy));
      check("overrun", 32'(overrun_o), 32'(m_ovr));
    end
  end

  // Independent receiver: samples mid-bit after each falling edge of tx_o.
  bit         rx_busy = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx_o == 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2 && rx_t > CPB && rx_t < 9 * CPB)
        rx_byte[rx_t / CPB - 1] = tx_o;
      if (rx_t == 9 * CPB + CPB / 2) begin
        check("rx_stop", 32'(tx_o), 32'h1);
        if (exp_q.size() == 0) check("rx_unexpected_frame", 32'h1, 32'h0);
        else check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        rx_busy = 1'b0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_count(input logic [3:0] v);
    @(negedge clk);
    count_i = v;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx_o), 32'h1);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);
    wait_cycles(2);
    #1 rst = 1'b0;
  endtask

  initial begin
    wait_cycles(3);
    check("reset_tx", 32'(tx_o), 32'h1);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_overrun", 32'(overrun_o), 32'h0);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // 0 -> 5 sends '5'
    set_count(4'h5);
    wait_cycles(FRAME + 5);
    // 9 -> A and F -> 0 boundaries
    set_count(4'h9); wait_cycles(FRAME + 4);
    set_count(4'hA); wait_cycles(FRAME + 4);
    set_count(4'hF); wait_cycles(FRAME + 4);
    set_count(4'h0); wait_cycles(FRAME + 4);
    // 1 -> 2 -> 3 inside one frame: only '3' follows, overrun sticks
    set_count(4'h1); wait_cycles(3);
    set_count(4'h2); wait_cycles(3);
    set_count(4'h3); wait_cycles(2 * FRAME + 4);
    check("overrun_sticky", 32'(overrun_o), 32'h1);
    // reset in the middle of data bit 4, then '7'
    set_count(4'h6); wait_cycles(1 + 5 * CPB);
    reset_pulse();
    set_count(4'h7); wait_cycles(FRAME + 4);
    // disabled changes are ignored, re-enabling without a change sends nothing
    en_i = 1'b0;
    set_count(4'h3); wait_cycles(2);
    set_count(4'h4); wait_cycles(FRAME);
    check("disabled_idle", 32'(busy_o), 32'h0);
    en_i = 1'b1;
    wait_cycles(FRAME);
    check("reenable_idle", 32'(busy_o), 32'h0);

    for (int i = 0; i < 300; i++) begin
      en_i = ($urandom_range(0, 9) != 0);
      set_count(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 39) == 0) reset_pulse();
      wait_cycles($urandom_range(1, FRAME + 10));
    end

    en_i = 1'b1;
    wait_cycles(3 * FRAME);
    check("drain_busy", 32'(busy_o), 32'h0);
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    check("drain_rx_idle", 32'(rx_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
